ssc_tx: RTL
===========

Name: ssc_tx

Overview:
- Spread-spectrum test transmitter: the signal source that feeds the per-channel correlators.
- Generates a DDS carrier, BPSK-spreads it with the same Galois PRN generator the correlator channels use, scales it by a programmable amplitude, and emits signed 16-bit samples with a one-cycle push strobe.
- Its ADC_out/push_out pair drives the correlators' ADC/pushADC inputs directly.
- Configured over the shared addr/Wdata/write/read/Rdata register bus.

Parameters:
- BASE, 16'h0800, register window base address (offsets below are relative to BASE).
- PRN_W, 14, PRN state and polynomial width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- addr  in  32  bus address; only [15:0] decoded.
- Wdata  in  32  bus write data.
- write  in  1  write strobe, one cycle per access.
- read  in  1  read strobe.
- Rdata  out  32  read data; combinational, 0 when not selected or read=0.
- ADC_out  out  16  signed sample.
- push_out  out  1  one-cycle sample-valid pulse.
- epoch  out  1  one-cycle pulse when the PRN state returns to its seed.

Behaviour:
- Registers (R/W unless noted):
  - +0x00 CTRL: bit0 run.
  - +0x04 RATE: sample tick every RATE+1 clocks.
  - +0x08 CAR_ADD.
  - +0x0C CAR_PHASE.
  - +0x10 CHIP_ADD.
  - +0x14 CHIP_PHASE.
  - +0x18 PRN: hob[31:28], poly[27:14], state[13:0]. A write also loads SEED=state[13:0].
  - +0x1C AMP: [15:0] unsigned.
  - +0x20 SAMPLE_CNT.
  - +0x24 STATUS (RO): bit0 epoch_seen, cleared by a read of STATUS.
  - +0x28 NOISE (optional feature only).
- Reset: all registers 0, ADC_out=0, push_out=0, epoch=0, divider=0, pipeline valid bits cleared. Reset mid-pipeline drops in-flight samples.
- Tick generator:
  - run=0 holds the divider at 0 and generates no ticks.
  - run=1: the divider counts 0..RATE and ticks on the cycle it equals RATE, then wraps to 0.
  - RATE=0 gives a tick every cycle.
- On tick:
  - CAR_PHASE += CAR_ADD and CHIP_PHASE += CHIP_ADD, both mod 2^32.
  - SAMPLE_CNT += 1.
  - Stage 0 captures the pre-update CAR_PHASE and the current chip bit = state[hob].
- PRN advance: on a tick where the new CHIP_PHASE[31]=1 and the old bit31=0:
  - x=state[hob]; state[hob]=0; state<<=1 (truncated to PRN_W); if x, state^=poly.
  - If the new state equals SEED: epoch pulses the same cycle the state register updates, and epoch_seen sets.
- Pipeline, 3 cycles, tick -> push_out:
  - S0: quad=phase[31:30]; sine addr = quad[0] ? ~phase[29:17] : phase[29:17]. Uses the existing 13-bit quarter-wave sine table.
  - S1: s = sine value; negate if quad[1]; negate again if chip bit=1. Two's complement, 16-bit.
  - S2: ADC_out = (s * {1'b0,AMP}) >>> 16, arithmetic, truncating. push_out=1 for this cycle. ADC_out holds its value between pushes.
- Simultaneous events:
  - A bus write in the same cycle as a tick update wins for the written register.
  - A STATUS read that coincides with an epoch leaves epoch_seen=1 (set wins).
- A write to CTRL clearing run does not flush the pipeline; samples already in flight still emit.

Optional Feature:
- Macro: SSC_TX_NOISE_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), stepped every tick.
  - NOISE[3:0]=k: S2 output += (signed lfsr) >>> k, saturating to 16'h7FFF/16'h8000.
  - k=15 yields noise in -1..0 only.
  - NOISE is readable/writable.
- Undefined: no LFSR; NOISE reads 0 and writes are ignored; output is noiseless.

Test Plan:
- Reset: hold rst=0 with bus and ticks active -> ADC_out=0, push_out=0, epoch=0, all registers read 0; after release, registers remain 0.
- Carrier quadrants: CAR_ADD=0x40000000, AMP=0x8000, PRN=0, CHIP_ADD=0, RATE=0, run=1 -> push_out every cycle after 3-cycle latency; ADC_out repeats 0x0000, 0x3FFF, 0x0000, 0xC000.
- Rate divider: RATE=3 -> push_out exactly every 4th clock; SAMPLE_CNT=25 after 100 clocks of run, counted from the run write.
- PRN sequence and epoch: PRN={4'd3, poly=14'h3, state=14'h1}, CHIP_ADD=0x80000000 -> state sequence 1,2,4,8,3,6,C,B,...; epoch pulses after exactly 15 chip advances; STATUS reads 1 then 0 on re-read.
- Spreading sign: AMP=0x8000, carrier at quad1 peak, chip bit toggling -> ADC_out alternates 0x3FFF/0xC000 in step with state[hob].
- Bus collision: write CAR_PHASE=0x12345678 on a tick cycle -> readback is 0x12345678, not the accumulated value. With SSC_TX_NOISE_EN and NOISE=15 -> outputs within 1 LSB of the noiseless sequence.

Source files
------------

// File: rtl/ssc_tx.sv
// ssc_tx: spread-spectrum test source: DDS carrier, BPSK PRN spreading, amplitude scaling.
// Define SSC_TX_NOISE_EN to add a scaled 16-bit LFSR noise term to every sample.
module ssc_tx #(
  parameter logic [15:0] BASE  = 16'h0800,
  parameter int          PRN_W = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  output logic [15:0] ADC_out,
  output logic        push_out,
  output logic        epoch
);

  logic [15:0] off;
  logic        hit;
  logic [3:0]  idx;
  logic        we;

  assign off = addr[15:0] - BASE;
  assign hit = (off < 16'h002C) && (off[1:0] == 2'b00);
  assign idx = off[5:2];
  assign we  = write && hit;

  logic             run;
  logic [31:0]      rate, div;
  logic [31:0]      car_add, car_phase;
  logic [31:0]      chip_add, chip_phase, chip_nxt;
  logic [3:0]       hob;
  logic [PRN_W-1:0] poly, state, seed;
  logic [15:0]      amp;
  logic [31:0]      sample_cnt;
  logic             epoch_seen;
  logic             tick, adv, chip, wrap;
  logic             rd_status;
  logic [PRN_W-1:0] shifted, cleared, state_nxt;

  assign tick      = run && (div == rate);
  assign chip_nxt  = chip_phase + chip_add;
  assign adv       = tick && chip_nxt[31] && !chip_phase[31];
  assign rd_status = read && hit && (idx == 4'd9);
  assign wrap      = adv && !(we && idx == 4'd6) && (state_nxt == seed);

  // Galois step: pull the hob tap, clear it, shift, fold poly back in.
  always_comb begin
    shifted   = state >> hob;
    chip      = shifted[0];
    cleared   = state & ~(PRN_W'(1) << hob);
    state_nxt = {cleared[PRN_W-2:0], 1'b0} ^ (chip ? poly : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run        <= 1'b0;
      rate       <= '0;
      div        <= '0;
      car_add    <= '0;
      car_phase  <= '0;
      chip_add   <= '0;
      chip_phase <= '0;
      hob        <= '0;
      poly       <= '0;
      state      <= '0;
      seed       <= '0;
      amp        <= '0;
      sample_cnt <= '0;
      epoch_seen <= 1'b0;
      epoch      <= 1'b0;
    end else begin
      if (we && idx == 4'd0) run <= Wdata[0];
      if (we && idx == 4'd1) rate <= Wdata;
      if (we && idx == 4'd2) car_add <= Wdata;
      if (we && idx == 4'd4) chip_add <= Wdata;
      if (we && idx == 4'd7) amp <= Wdata[15:0];

      if (we && idx == 4'd3)  car_phase <= Wdata;
      else if (tick)          car_phase <= car_phase + car_add;
      if (we && idx == 4'd5)  chip_phase <= Wdata;
      else if (tick)          chip_phase <= chip_nxt;
      if (we && idx == 4'd8)  sample_cnt <= Wdata;
      else if (tick)          sample_cnt <= sample_cnt + 32'd1;

      if (we && idx == 4'd6) begin
        hob   <= Wdata[31:28];
        poly  <= Wdata[2*PRN_W-1:PRN_W];
        state <= Wdata[PRN_W-1:0];
        seed  <= Wdata[PRN_W-1:0];
      end else if (adv) begin
        state <= state_nxt;
      end

      epoch <= wrap;
      if (wrap)           epoch_seen <= 1'b1;
      else if (rd_status) epoch_seen <= 1'b0;

      if (!run || tick) div <= '0;
      else              div <= div + 32'd1;
    end
  end

  logic [1:0]         quad0;
  logic [12:0]        a0;
  logic               chip0, v0, v1;
  logic [27:0]        sq;
  logic [15:0]        sine;
  logic signed [15:0] s1;
  logic signed [32:0] prod;
  logic [15:0]        scaled, result;
  logic [31:0]        noise_rd;

  // Parabolic quarter-wave table: sin(pi/2*x) ~ x*(2-x), x = a/8192.
  assign sq     = 28'(a0) * (28'd16384 - 28'(a0));
  assign sine   = {1'b0, sq[25:11]};
  assign prod   = s1 * $signed({1'b0, amp});
  assign scaled = prod[31:16];

`ifdef SSC_TX_NOISE_EN
  logic [15:0]        lfsr;
  logic [3:0]         noise;
  logic signed [15:0] nz;
  logic signed [16:0] sum;

  assign nz       = $signed(lfsr) >>> noise;
  assign sum      = {scaled[15], scaled} + {nz[15], nz};
  assign result   = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
  assign noise_rd = {28'b0, noise};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr  <= 16'hACE1;
      noise <= '0;
    end else begin
      if (we && idx == 4'd10) noise <= Wdata[3:0];
      if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
`else
  assign result   = scaled;
  assign noise_rd = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      quad0    <= '0;
      a0       <= '0;
      chip0    <= 1'b0;
      s1       <= '0;
      push_out <= 1'b0;
      ADC_out  <= '0;
    end else begin
      v0       <= tick;
      quad0    <= car_phase[31:30];
      a0       <= car_phase[30] ? ~car_phase[29:17] : car_phase[29:17];
      chip0    <= chip;
      v1       <= v0;
      s1       <= (quad0[1] ^ chip0) ? -$signed(sine) : $signed(sine);
      push_out <= v1;
      if (v1) ADC_out <= result;
    end
  end

  always_comb begin
    Rdata = '0;
    if (read && hit) begin
      case (idx)
        4'd0:    Rdata = {31'b0, run};
        4'd1:    Rdata = rate;
        4'd2:    Rdata = car_add;
        4'd3:    Rdata = car_phase;
        4'd4:    Rdata = chip_add;
        4'd5:    Rdata = chip_phase;
        4'd6:    Rdata = {hob, poly, state};
        4'd7:    Rdata = {16'b0, amp};
        4'd8:    Rdata = sample_cnt;
        4'd9:    Rdata = {31'b0, epoch_seen};
        4'd10:   Rdata = noise_rd;
        default: Rdata = '0;
      endcase
    end
  end

  logic unused;
  assign unused = ^{addr[31:16], shifted[PRN_W-1:1], cleared[PRN_W-1],
                    sq[27:26], sq[10:0], prod[32], prod[15:0]};

endmodule
